// File: rtl/dsp38_arb_pkg.sv
// rtl/dsp38_arb_pkg.sv - shared constants and types for the DSP38 multiplier arbiter
//
// Contents:
//   A_WIDTH / B_WIDTH / Z_WIDTH : DSP38 multiplier pin widths (fixed by the primitive)
//   operand_t                   : one operand pair plus its signedness flags
//   occ_t                       : pipeline occupancy, encoded as {op_vld, res_vld}
package dsp38_arb_pkg;

  localparam int A_WIDTH = 20;
  localparam int B_WIDTH = 18;
  localparam int Z_WIDTH = 38;

  typedef struct packed {
    logic [A_WIDTH-1:0] a;
    logic [B_WIDTH-1:0] b;
    logic               unsigned_a;
    logic               unsigned_b;
  } operand_t;

  // Bit 1 is the OP stage valid, bit 0 the RES stage valid.
  typedef enum logic [1:0] {
    OCC_EMPTY    = 2'b00,
    OCC_RES_ONLY = 2'b01,
    OCC_OP_ONLY  = 2'b10,
    OCC_FULL     = 2'b11
  } occ_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter with external pointer
//
// Ports:
//   req : request vector, one bit per client
//   ptr : index of the highest-priority client this cycle
//   en  : grant enable; when low no grant is issued
//   gnt : one-hot grant (all zero when en is low or no request is set)
//
// The pointer is kept by the parent so it can decide when a grant really
// counts (e.g. only on an actual handshake).
module rr_arbiter
  import dsp38_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt
);

  logic found;

  // First pass looks at indices ptr..NUM_REQ-1, second pass wraps to 0..ptr-1.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i] && (i >= int'(ptr))) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i]) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
    if (!en) begin
      gnt = '0;
    end
  end

endmodule

// File: rtl/dsp38_mult_arbiter.sv
// rtl/dsp38_mult_arbiter.sv - round-robin sharing of one DSP38 multiplier among NUM_REQ clients
//
// Ports:
//   clk, reset                      : clock, asynchronous active-low reset
//   req_valid / req_ready           : per-client operand handshake (req_ready one-hot or zero)
//   req_a / req_b                   : packed operands, client i at [i*W +: W]
//   req_unsigned_a / req_unsigned_b : per-client signedness (1 = unsigned)
//   dsp_a / dsp_b / dsp_unsigned_*  : registered operands driving the DSP38
//   dsp_z                           : DSP38 product, combinational from dsp_a/dsp_b
//   rsp_valid / rsp_ready           : result handshake
//   rsp_z / rsp_id                  : product and owning client index
//
// Two stages: OP holds the operands on the DSP pins, RES captures dsp_z.
// At most two operations are in flight; grants stop when both stages are
// stuck behind a stalled consumer.
module dsp38_mult_arbiter
  import dsp38_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]         req_unsigned_a,
  input  logic [NUM_REQ-1:0]         req_unsigned_b,
  output logic [A_WIDTH-1:0]         dsp_a,
  output logic [B_WIDTH-1:0]         dsp_b,
  output logic                       dsp_unsigned_a,
  output logic                       dsp_unsigned_b,
  input  logic [Z_WIDTH-1:0]         dsp_z,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [Z_WIDTH-1:0]         rsp_z,
  output logic [ID_WIDTH-1:0]        rsp_id
);

  localparam int PTR_W = $clog2(NUM_REQ);

  occ_t                occ_q;
  occ_t                occ_d;
  logic                op_vld;
  logic                res_vld;
  logic                res_adv;
  logic                can_accept;
  logic                accept;
  logic [NUM_REQ-1:0]  gnt;
  logic [PTR_W-1:0]    ptr_q;
  logic [PTR_W-1:0]    ptr_nxt;
  logic [PTR_W-1:0]    gnt_idx;
  operand_t            sel_op;
  operand_t            op_q;
  logic [ID_WIDTH-1:0] op_id_q;
  logic [Z_WIDTH-1:0]  z_q;
  logic [ID_WIDTH-1:0] id_q;

  assign op_vld  = (occ_q == OCC_OP_ONLY) || (occ_q == OCC_FULL);
  assign res_vld = (occ_q == OCC_RES_ONLY) || (occ_q == OCC_FULL);

  // OP moves into RES whenever RES is empty or being drained this cycle.
  assign res_adv    = op_vld && (!res_vld || rsp_ready);
  assign can_accept = !op_vld || res_adv;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .req (req_valid),
    .ptr (ptr_q),
    .en  (can_accept),
    .gnt (gnt)
  );

  assign req_ready = gnt;
  assign accept    = |gnt;

  // Encode the one-hot grant and pick the winning operand slot.
  always_comb begin
    gnt_idx = '0;
    sel_op  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        gnt_idx           = PTR_W'(i);
        sel_op.a          = req_a[i*A_WIDTH +: A_WIDTH];
        sel_op.b          = req_b[i*B_WIDTH +: B_WIDTH];
        sel_op.unsigned_a = req_unsigned_a[i];
        sel_op.unsigned_b = req_unsigned_b[i];
      end
    end
  end

  assign ptr_nxt = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);

  // Occupancy next state. In OP_ONLY the OP stage always advances, so the
  // only question is whether a new operand refills it.
  always_comb begin
    occ_d = occ_q;
    case (occ_q)
      OCC_EMPTY:    occ_d = accept ? OCC_OP_ONLY : OCC_EMPTY;
      OCC_OP_ONLY:  occ_d = accept ? OCC_FULL : OCC_RES_ONLY;
      OCC_RES_ONLY: begin
        if (accept) begin
          occ_d = rsp_ready ? OCC_OP_ONLY : OCC_FULL;
        end else begin
          occ_d = rsp_ready ? OCC_EMPTY : OCC_RES_ONLY;
        end
      end
      OCC_FULL: begin
        if (rsp_ready) begin
          occ_d = accept ? OCC_FULL : OCC_RES_ONLY;
        end else begin
          occ_d = OCC_FULL;
        end
      end
      default:      occ_d = OCC_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ_q <= OCC_EMPTY;
    end else begin
      occ_q <= occ_d;
    end
  end

  // Operand registers only load on accept so idle cycles leave the DSP
  // inputs untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q   <= '0;
      op_q    <= '0;
      op_id_q <= '0;
      z_q     <= '0;
      id_q    <= '0;
    end else begin
      if (accept) begin
        op_q    <= sel_op;
        op_id_q <= ID_WIDTH'(gnt_idx);
        ptr_q   <= ptr_nxt;
      end
      if (res_adv) begin
        z_q  <= dsp_z;
        id_q <= op_id_q;
      end
    end
  end

  assign dsp_a          = op_q.a;
  assign dsp_b          = op_q.b;
  assign dsp_unsigned_a = op_q.unsigned_a;
  assign dsp_unsigned_b = op_q.unsigned_b;

  assign rsp_valid = res_vld;
  assign rsp_z     = z_q;
  assign rsp_id    = id_q;

  // Requesters must hold valid and operands steady until granted.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_hold_chk
    a_req_hold : assert property (@(posedge clk) disable iff (!reset)
      (req_valid[i] && !req_ready[i]) |=>
        (req_valid[i] &&
         $stable(req_a[i*A_WIDTH +: A_WIDTH]) &&
         $stable(req_b[i*B_WIDTH +: B_WIDTH]) &&
         $stable(req_unsigned_a[i]) &&
         $stable(req_unsigned_b[i])));
  end

endmodule
